spi_ram_arbiter: RTL and testbench



---
 rtl/spi_ram_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_spi_ram_arbiter.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_ram_arbiter.sv
// -----------------------------------------------------------------------------
// spi_ram_arbiter
//
// Arbitrates a single-port RAM between SPI frames received from the SPI slave
// and a local host port. SPI frames carry a 2-bit command and an 8-bit payload:
//   00 set write address, 01 write payload, 10 set read address, 11 read.
// Address commands never touch the RAM and retire in any ARB cycle. RAM
// commands (SPI 01/11 and host requests) are arbitrated round-robin against
// last_grant and issued as single-cycle RAM accesses.
//
// Ports
//   clk, rst_n                 clock, asynchronous active-low reset
//   spi_rx_data[9:0]           {cmd[1:0], payload[7:0]} from the SPI slave
//   spi_rx_valid               level from the slave, rising edge = new frame
//   spi_ss_n                   slave select, high releases spi_tx_valid
//   spi_tx_data/spi_tx_valid   read data returned to the slave
//   host_req/we/addr/wdata     host request, held until host_gnt
//   host_gnt                   pulse in the host access issue cycle
//   host_rdata/host_rvalid     host read data, rvalid is a one-cycle pulse
//   mem_en/we/addr/wdata       RAM command, all zero while mem_en is low
//   mem_rdata                  RAM read data, valid the cycle after the read
//   spi_overflow               sticky, a SPI frame was dropped
//   busy                       FSM is not in ARB
// -----------------------------------------------------------------------------
module spi_ram_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [9:0]            spi_rx_data,
  input  logic                  spi_rx_valid,
  input  logic                  spi_ss_n,
  output logic [7:0]            spi_tx_data,
  output logic                  spi_tx_valid,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  output logic                  host_gnt,
  output logic [7:0]            host_rdata,
  output logic                  host_rvalid,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  spi_overflow,
  output logic                  busy
);

  localparam int DATA_W = 8;

  localparam logic [1:0] CMD_SET_WR = 2'b00;
  localparam logic [1:0] CMD_WRITE  = 2'b01;
  localparam logic [1:0] CMD_SET_RD = 2'b10;
  localparam logic [1:0] CMD_READ   = 2'b11;

  typedef enum logic [1:0] {
    ARB        = 2'd0,
    WR_ISSUE   = 2'd1,
    RD_ISSUE   = 2'd2,
    RD_CAPTURE = 2'd3
  } state_t;

  typedef enum logic {
    GRANT_SPI  = 1'b0,
    GRANT_HOST = 1'b1
  } grant_t;

  // Zero-extend or truncate the 8-bit SPI payload to the RAM address width.
  function automatic logic [ADDR_WIDTH-1:0] fit_addr(input logic [DATA_W-1:0] p);
    logic [ADDR_WIDTH-1:0] a;
    a = '0;
    for (int i = 0; i < ADDR_WIDTH; i++) begin
      a[i] = (i < DATA_W) ? p[i[2:0]] : 1'b0;
    end
    return a;
  endfunction

  state_t                state;
  grant_t                last_grant;
  logic                  spi_rx_valid_p0;
  logic                  slot_full;
  logic [1:0]            slot_cmd;
  logic [DATA_W-1:0]     slot_payload;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  op_host;

  logic                  rx_edge;
  logic                  spi_contend;
  logic                  host_contend;
  logic                  grant_spi;
  logic                  grant_host;
  logic                  slot_consume;
  logic                  rd_cmd_accepted;
  logic                  op_we;
  logic [ADDR_WIDTH-1:0] op_addr;
  logic [DATA_W-1:0]     op_wdata;

  assign rx_edge = spi_rx_valid && !spi_rx_valid_p0;
  assign busy    = (state != ARB);

  always_comb begin
    spi_contend  = (state == ARB) && slot_full && slot_cmd[0];
    host_contend = (state == ARB) && host_req;
    // With both contending, the requester that did not win last time goes.
    grant_spi    = spi_contend && (!host_contend || (last_grant == GRANT_HOST));
    grant_host   = host_contend && !grant_spi;
    // Address commands retire in any ARB cycle; RAM commands only when granted.
    slot_consume = (state == ARB) && slot_full && (!slot_cmd[0] || grant_spi);
    // A new read frame entering the slot releases the previous read data.
    rd_cmd_accepted = rx_edge && (spi_rx_data[9:8] == CMD_READ) &&
                      (!slot_full || slot_consume);

    op_we    = 1'b0;
    op_addr  = '0;
    op_wdata = '0;
    if (grant_host) begin
      op_we    = host_we;
      op_addr  = host_addr;
      op_wdata = host_wdata;
    end else if (grant_spi) begin
      op_we    = (slot_cmd == CMD_WRITE);
      op_addr  = (slot_cmd == CMD_WRITE) ? wr_addr : rd_addr;
      op_wdata = (slot_cmd == CMD_WRITE) ? slot_payload : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= ARB;
      last_grant      <= GRANT_HOST;
      spi_rx_valid_p0 <= 1'b0;
      slot_full       <= 1'b0;
      slot_cmd        <= '0;
      slot_payload    <= '0;
      wr_addr         <= '0;
      rd_addr         <= '0;
      op_host         <= 1'b0;
      spi_tx_data     <= '0;
      spi_tx_valid    <= 1'b0;
      host_gnt        <= 1'b0;
      host_rdata      <= '0;
      host_rvalid     <= 1'b0;
      mem_en          <= 1'b0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      spi_overflow    <= 1'b0;
    end else begin
      spi_rx_valid_p0 <= spi_rx_valid;

      // RAM command and grant are single-cycle; idle values are all zero.
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      host_gnt    <= 1'b0;
      host_rvalid <= 1'b0;

      // One-entry pending slot for SPI frames.
      if (rx_edge && slot_full && !slot_consume) begin
        spi_overflow <= 1'b1;
      end else if (rx_edge) begin
        slot_full    <= 1'b1;
        slot_cmd     <= spi_rx_data[9:8];
        slot_payload <= spi_rx_data[7:0];
      end else if (slot_consume) begin
        slot_full <= 1'b0;
      end

      if (spi_ss_n || rd_cmd_accepted) begin
        spi_tx_valid <= 1'b0;
      end

      case (state)
        // Stage: arbitration and address-command decode
        ARB: begin
          if (slot_full && (slot_cmd == CMD_SET_WR)) begin
            wr_addr <= fit_addr(slot_payload);
          end
          if (slot_full && (slot_cmd == CMD_SET_RD)) begin
            rd_addr <= fit_addr(slot_payload);
          end
          if (grant_spi || grant_host) begin
            mem_en     <= 1'b1;
            mem_we     <= op_we;
            mem_addr   <= op_addr;
            mem_wdata  <= op_we ? op_wdata : '0;
            host_gnt   <= grant_host;
            op_host    <= grant_host;
            last_grant <= grant_host ? GRANT_HOST : GRANT_SPI;
            state      <= op_we ? WR_ISSUE : RD_ISSUE;
          end
        end
        // Stage: write presented to the RAM
        WR_ISSUE: begin
          state <= ARB;
        end
        // Stage: read presented to the RAM
        RD_ISSUE: begin
          state <= RD_CAPTURE;
        end
        // Stage: read data returned by the RAM
        RD_CAPTURE: begin
          if (op_host) begin
            host_rdata  <= mem_rdata;
            host_rvalid <= 1'b1;
          end else begin
            spi_tx_data  <= mem_rdata;
            spi_tx_valid <= !spi_ss_n;
          end
          state <= ARB;
        end
        default: state <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
module tb_spi_ram_arbiter;

  logic       clk;
  logic       rst_n;
  logic [9:0] spi_rx_data;
  logic       spi_rx_valid;
  logic       spi_ss_n;
  logic [7:0] spi_tx_data;
  logic       spi_tx_valid;
  logic       host_req;
  logic       host_we;
  logic [7:0] host_addr;
  logic [7:0] host_wdata;
  logic       host_gnt;
  logic [7:0] host_rdata;
  logic       host_rvalid;
  logic       mem_en;
  logic       mem_we;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic       spi_overflow;
  logic       busy;

  spi_ram_arbiter #(.ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .spi_rx_data(spi_rx_data), .spi_rx_valid(spi_rx_valid), .spi_ss_n(spi_ss_n),
    .spi_tx_data(spi_tx_data), .spi_tx_valid(spi_tx_valid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_gnt(host_gnt),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .spi_overflow(spi_overflow), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural single-port RAM with registered read data.
  logic [7:0] ram [256];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  typedef struct packed {
    logic       we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       host;
  } mem_exp_t;

  mem_exp_t   exp_mem[$];
  logic [7:0] exp_spi[$];
  logic [7:0] exp_host[$];

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a response.
  logic prev_mem_en = 1'b0;
  logic prev_spi_vld = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (mem_en) begin
        mem_exp_t e;
        check("mem_en_not_consecutive", {31'd0, prev_mem_en}, 32'd0);
        if (exp_mem.size() == 0) begin
          check("mem_unexpected_access", 32'd1, 32'd0);
        end else begin
          e = exp_mem.pop_front();
          check("mem_access",
                {14'd0, mem_we, mem_addr, host_gnt, (mem_we ? mem_wdata : 8'h00)},
                {14'd0, e.we, e.addr, e.host, (e.we ? e.wdata : 8'h00)});
        end
      end else begin
        check("mem_idle_zero", {14'd0, host_gnt, mem_we, mem_addr, mem_wdata}, 32'd0);
      end
      if (host_rvalid) begin
        if (exp_host.size() == 0) check("host_rvalid_unexpected", 32'd1, 32'd0);
        else check("host_rdata", {24'd0, host_rdata}, {24'd0, exp_host.pop_front()});
      end
      if (spi_tx_valid && !prev_spi_vld) begin
        if (exp_spi.size() == 0) check("spi_tx_unexpected", 32'd1, 32'd0);
        else check("spi_tx_data", {24'd0, spi_tx_data}, {24'd0, exp_spi.pop_front()});
      end
    end
    prev_mem_en  = mem_en;
    prev_spi_vld = spi_tx_valid;
  end

  function automatic mem_exp_t mk(input logic we, input logic [7:0] a,
                                  input logic [7:0] d, input logic h);
    mem_exp_t e;
    e.we = we; e.addr = a; e.wdata = d; e.host = h;
    return e;
  endfunction

  task automatic spi_send(input logic [1:0] cmd, input logic [7:0] payload);
    @(negedge clk);
    spi_rx_data  = {cmd, payload};
    spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
  endtask

  int gnt_cnt;
  int gnt_k;

  initial begin
    for (int i = 0; i < 256; i++) ram[i] = 8'h00;
    ram[8'h05] = 8'h5A;
    ram[8'h44] = 8'hC3;
    mem_rdata    = 8'h00;
    rst_n        = 1'b0;
    spi_rx_data  = '0;
    spi_rx_valid = 1'b0;
    spi_ss_n     = 1'b0;
    host_req     = 1'b0;
    host_we      = 1'b0;
    host_addr    = '0;
    host_wdata   = '0;
    idle(3);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_outputs",
          {spi_tx_data, host_rdata, spi_tx_valid, host_gnt, host_rvalid, mem_en,
           mem_we, spi_overflow, busy, 1'b0, mem_addr | mem_wdata}, 32'd0);

    // SPI write: set address 0x12, then write 0xAB.
    exp_mem.push_back(mk(1'b1, 8'h12, 8'hAB, 1'b0));
    spi_send(2'b00, 8'h12);
    spi_send(2'b01, 8'hAB);
    idle(4);

    // SPI read of 0x12: response three cycles after the decision.
    exp_mem.push_back(mk(1'b0, 8'h12, 8'h00, 1'b0));
    exp_spi.push_back(8'hAB);
    spi_send(2'b10, 8'h12);
    spi_send(2'b11, 8'h00);
    @(negedge clk);
    check("rd_issue_mem_en", {31'd0, mem_en}, 32'd1);
    @(negedge clk);
    check("spi_tx_valid_early", {31'd0, spi_tx_valid}, 32'd0);
    @(negedge clk);
    check("spi_tx_valid_n3", {23'd0, spi_tx_valid, spi_tx_data}, {23'd0, 1'b1, 8'hAB});
    spi_ss_n = 1'b1;
    @(negedge clk);
    check("spi_tx_release_ss", {23'd0, spi_tx_valid, spi_tx_data}, {23'd0, 1'b0, 8'hAB});
    spi_ss_n = 1'b0;
    idle(2);

    // Host write and SPI write contend from reset: SPI first, host two cycles later.
    do_reset();
    exp_mem.push_back(mk(1'b1, 8'h00, 8'h77, 1'b0));
    exp_mem.push_back(mk(1'b1, 8'h30, 8'h99, 1'b1));
    @(negedge clk);
    spi_rx_data  = {2'b01, 8'h77};
    spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b1; host_addr = 8'h30; host_wdata = 8'h99;
    gnt_cnt = 0;
    gnt_k   = 0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (host_gnt) begin
        gnt_cnt++;
        if (gnt_k == 0) gnt_k = k;
        host_req = 1'b0;
      end
    end
    host_req = 1'b0;
    check("host_gnt_count", gnt_cnt, 1);
    check("host_gnt_cycle", gnt_k, 3);

    // Host read of 0x05 while an SPI set-read-address frame is pending.
    exp_mem.push_back(mk(1'b0, 8'h05, 8'h00, 1'b1));
    exp_host.push_back(8'h5A);
    @(negedge clk);
    spi_rx_data  = {2'b10, 8'h44};
    spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    @(negedge clk);
    check("host_rd_gnt_busy", {30'd0, host_gnt, busy}, 32'd3);
    host_req = 1'b0;
    @(negedge clk);
    check("host_rvalid_early", {31'd0, host_rvalid}, 32'd0);
    @(negedge clk);
    check("host_rvalid_n3", {23'd0, host_rvalid, host_rdata}, {23'd0, 1'b1, 8'h5A});
    idle(2);
    // Read through the address set alongside the host read.
    exp_mem.push_back(mk(1'b0, 8'h44, 8'h00, 1'b0));
    exp_spi.push_back(8'hC3);
    spi_send(2'b11, 8'h00);
    idle(5);

    // Overflow: second SPI edge while the slot is full and a host read is busy.
    exp_mem.push_back(mk(1'b0, 8'h05, 8'h00, 1'b1));
    exp_host.push_back(8'h5A);
    exp_mem.push_back(mk(1'b0, 8'h44, 8'h00, 1'b0));
    exp_spi.push_back(8'hC3);
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    spi_rx_data  = {2'b11, 8'h00};
    spi_rx_valid = 1'b1;
    @(negedge clk);
    check("ovf_host_gnt", {31'd0, host_gnt}, 32'd1);
    check("spi_tx_release_rdcmd", {31'd0, spi_tx_valid}, 32'd0);
    host_req = 1'b0;
    spi_rx_valid = 1'b0;
    @(negedge clk);
    check("overflow_before", {31'd0, spi_overflow}, 32'd0);
    spi_rx_data  = {2'b01, 8'hEE};
    spi_rx_valid = 1'b1;
    @(negedge clk);
    spi_rx_valid = 1'b0;
    check("overflow_set", {31'd0, spi_overflow}, 32'd1);
    idle(8);
    check("overflow_sticky", {31'd0, spi_overflow}, 32'd1);

    // Asynchronous reset during RD_ISSUE.
    exp_mem.push_back(mk(1'b0, 8'h05, 8'h00, 1'b1));
    @(negedge clk);
    host_req = 1'b1; host_we = 1'b0; host_addr = 8'h05;
    @(negedge clk);
    check("rst_mid_issue_en", {31'd0, mem_en}, 32'd1);
    host_req = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs",
          {spi_tx_data, host_rdata, spi_tx_valid, host_gnt, host_rvalid, mem_en,
           mem_we, spi_overflow, busy, 1'b0, mem_addr | mem_wdata}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("post_reset_quiet", {28'd0, host_rvalid, spi_tx_valid, mem_en, busy}, 32'd0);
    end

    check("exp_mem_drained", exp_mem.size(), 0);
    check("exp_spi_drained", exp_spi.size(), 0);
    check("exp_host_drained", exp_host.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
